mem_arbiter: RTL and testbench

Shares one single-port, synchronous-read word RAM between the instruction-fetch port and the data-memory port of the unified-memory CPU variants. Grants at most one access per cycle, data port over fetch, with an optional starvation guard for fetch. Routes each read response back to its requester one cycle after the grant. Sits between the CPU core and the RAM instance that test programs are loaded into.

---
 rtl/mips_pkg.sv | 15 +
 rtl/arb_starve_counter.sv | 38 +++
 rtl/mem_arbiter.sv | 117 +++++++++++
 tb/tb_mem_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types for the unified-memory CPU blocks.
// No logic; types and constants only.
// No flow control here.
package mips_pkg;

    localparam int WORD_W = 32;

    // Which requester owns the read data returning from the RAM this cycle.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PEND_I = 2'd1,
        PEND_D = 2'd2
    } arb_resp_t;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of consecutive cycles the fetch port was denied.
// Latency: at_limit is registered, reflects counts up to the previous edge.
// Backpressure: none; clr has priority over inc.
module arb_starve_counter #(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    // Next count: clear wins, otherwise count up and stick at LIMIT.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = 4'd0;
        end else if (inc && (cnt_q != 4'(LIMIT))) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_limit = (cnt_q == 4'(LIMIT));

endmodule

// File: rtl/mem_arbiter.sv
// Shares one synchronous-read RAM between fetch and data ports; data wins,
// optional fetch starvation guard (ARB_STARVE_GUARD_EN). Grant is same-cycle,
// read data returns one cycle after grant. Loser simply sees gnt=0 and holds.
module mem_arbiter
    import mips_pkg::*;
#(
    parameter int MEM_DEPTH    = 256,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_req,
    input  logic [WORD_W-1:0]            i_addr,
    output logic                         i_gnt,
    output logic                         i_rvalid,
    output logic [WORD_W-1:0]            i_rdata,
    input  logic                         d_req,
    input  logic                         d_we,
    input  logic [WORD_W-1:0]            d_addr,
    input  logic [WORD_W-1:0]            d_wdata,
    output logic                         d_gnt,
    output logic                         d_rvalid,
    output logic [WORD_W-1:0]            d_rdata,
    output logic                         m_en,
    output logic                         m_we,
    output logic [$clog2(MEM_DEPTH)-1:0] m_addr,
    output logic [WORD_W-1:0]            m_wdata,
    input  logic [WORD_W-1:0]            m_rdata
);

    localparam int AW = $clog2(MEM_DEPTH);

    logic      force_i;
    arb_resp_t resp_st_q;
    arb_resp_t resp_st_d;

`ifdef ARB_STARVE_GUARD_EN
    // Fetch is forced to win once it has been denied STARVE_LIMIT cycles running.
    arb_starve_counter #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk      (clk),
        .reset    (reset),
        .inc      (i_req && !i_gnt),
        .clr      (!i_req || i_gnt),
        .at_limit (force_i)
    );
`else
    assign force_i = 1'b0;

    // Limit only matters when the guard is built in.
    logic unused_limit;
    assign unused_limit = ^STARVE_LIMIT;
`endif

    // Byte offset and bits above the RAM depth are deliberately ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_addr[1:0], i_addr[WORD_W-1:AW+2],
                                d_addr[1:0], d_addr[WORD_W-1:AW+2]};

    // Grant decision and RAM command; everything quiet while in reset.
    always_comb begin
        i_gnt   = 1'b0;
        d_gnt   = 1'b0;
        m_en    = 1'b0;
        m_we    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        if (reset) begin
            if (force_i && i_req) begin
                i_gnt = 1'b1;
            end else if (d_req) begin
                d_gnt = 1'b1;
            end else if (i_req) begin
                i_gnt = 1'b1;
            end

            if (d_gnt) begin
                m_en    = 1'b1;
                m_we    = d_we;
                m_addr  = d_addr[AW+1:2];
                m_wdata = d_wdata;
            end else if (i_gnt) begin
                m_en   = 1'b1;
                m_addr = i_addr[AW+1:2];
            end
        end
    end

    // Owner of next cycle's RAM read data; writes produce no response.
    always_comb begin
        resp_st_d = IDLE;
        if (i_gnt) begin
            resp_st_d = PEND_I;
        end else if (d_gnt && !d_we) begin
            resp_st_d = PEND_D;
        end
    end

    // Response state register; reset drops any in-flight response.
    always_ff @(posedge clk) begin
        if (!reset) begin
            resp_st_q <= IDLE;
        end else begin
            resp_st_q <= resp_st_d;
        end
    end

    // Steer RAM data to its owner; zero on the other port and during reset.
    always_comb begin
        i_rvalid = reset && (resp_st_q == PEND_I);
        d_rvalid = reset && (resp_st_q == PEND_D);
        i_rdata  = i_rvalid ? m_rdata : '0;
        d_rdata  = d_rvalid ? m_rdata : '0;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic
// against a request-level model with its own shadow memory.
module tb_mem_arbiter;

    localparam int DEPTH = 256;
    localparam int LIMIT = 4;
`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        m_en;
    logic        m_we;
    logic [7:0]  m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;

    int checks = 0;
    int failures = 0;

    mem_arbiter #(
        .MEM_DEPTH    (DEPTH),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_gnt    (i_gnt),
        .i_rvalid (i_rvalid),
        .i_rdata  (i_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .m_en     (m_en),
        .m_we     (m_we),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_rdata  (m_rdata)
    );

    always #5 clk = ~clk;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Bench-owned RAM: registered read, write at the edge.
    logic [31:0] ram [DEPTH];
    always @(posedge clk) begin
        if (m_en) begin
            if (m_we) ram[m_addr] = m_wdata;
            else      m_rdata = ram[m_addr];
        end
    end

    // Request-level model: who wins, what each port sees next cycle.
    logic [31:0] shadow [DEPTH];
    int          starve = 0;
    bit          pend_i = 0;
    bit          pend_d = 0;
    logic [31:0] pend_data = '0;
    bit          exp_iwin;
    bit          exp_dwin;

    function automatic logic [7:0] widx(logic [31:0] a);
        return a[9:2];
    endfunction

    // Compare every output against the model away from the active edge.
    always @(negedge clk) begin
        bit          frc;
        logic [7:0]  ea;
        logic [31:0] ew;
        frc      = GUARD && (starve == LIMIT) && i_req;
        exp_dwin = reset && d_req && !frc;
        exp_iwin = reset && i_req && !exp_dwin;
        ea = exp_dwin ? widx(d_addr) : (exp_iwin ? widx(i_addr) : 8'd0);
        ew = exp_dwin ? d_wdata : 32'd0;
        chk("m_i_gnt", {31'd0, i_gnt}, {31'd0, exp_iwin});
        chk("m_d_gnt", {31'd0, d_gnt}, {31'd0, exp_dwin});
        chk("m_en", {31'd0, m_en}, {31'd0, exp_iwin || exp_dwin});
        chk("m_we", {31'd0, m_we}, {31'd0, exp_dwin && d_we});
        chk("m_addr", {24'd0, m_addr}, {24'd0, ea});
        chk("m_wdata", m_wdata, ew);
        chk("m_i_rvalid", {31'd0, i_rvalid}, {31'd0, reset && pend_i});
        chk("m_d_rvalid", {31'd0, d_rvalid}, {31'd0, reset && pend_d});
        chk("m_i_rdata", i_rdata, (reset && pend_i) ? pend_data : 32'd0);
        chk("m_d_rdata", d_rdata, (reset && pend_d) ? pend_data : 32'd0);
    end

    // Advance the model with the decisions made for this cycle.
    always @(posedge clk) begin
        if (!reset) begin
            pend_i = 0;
            pend_d = 0;
            starve = 0;
        end else begin
            pend_i = exp_iwin;
            pend_d = exp_dwin && !d_we;
            if (exp_dwin && d_we) shadow[widx(d_addr)] = d_wdata;
            if (exp_iwin)                pend_data = shadow[widx(i_addr)];
            else if (exp_dwin && !d_we)  pend_data = shadow[widx(d_addr)];
            if (i_req && !exp_iwin) starve = (starve < LIMIT) ? starve + 1 : LIMIT;
            else                    starve = 0;
        end
    end

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int k = 0; k < DEPTH; k++) begin
            ram[k]    = 32'hC0DE_0000 | k;
            shadow[k] = 32'hC0DE_0000 | k;
        end
        reset = 1'b0; i_req = 1'b1; i_addr = 32'h10;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;

        // Reset held two cycles with a pending fetch.
        for (int c = 0; c < 2; c++) begin
            sample();
            chk("rst_i_gnt", {31'd0, i_gnt}, 32'd0);
            chk("rst_m_en", {31'd0, m_en}, 32'd0);
            chk("rst_rvalid", {30'd0, i_rvalid, d_rvalid}, 32'd0);
            advance();
        end
        reset = 1'b1;
        sample();
        chk("fetch_gnt", {31'd0, i_gnt}, 32'd1);
        chk("fetch_addr", {24'd0, m_addr}, 32'd4);
        advance();
        i_req = 1'b0;
        sample();
        chk("fetch_rvalid", {31'd0, i_rvalid}, 32'd1);
        chk("fetch_rdata", i_rdata, 32'hC0DE_0004);
        advance();

        // Contention: data beats fetch, fetch goes once data drops.
        i_req = 1'b1; i_addr = 32'h8; d_req = 1'b1; d_we = 1'b0; d_addr = 32'hC;
        sample();
        chk("cont_d_gnt", {31'd0, d_gnt}, 32'd1);
        chk("cont_i_gnt", {31'd0, i_gnt}, 32'd0);
        advance();
        d_req = 1'b0;
        sample();
        chk("cont_d_rdata", d_rdata, 32'hC0DE_0003);
        chk("cont_i_gnt2", {31'd0, i_gnt}, 32'd1);
        advance();
        i_req = 1'b0;

        // Write then read the same word; high address bits ignored.
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0040_0020; d_wdata = 32'h2A;
        sample();
        chk("wr_gnt", {30'd0, d_gnt, m_we}, 32'd3);
        chk("wr_addr", {24'd0, m_addr}, 32'd8);
        advance();
        d_we = 1'b0; d_addr = 32'h20; d_wdata = '0;
        sample();
        chk("wr_no_rvalid", {31'd0, d_rvalid}, 32'd0);
        advance();
        d_req = 1'b0;
        sample();
        chk("raw_rdata", d_rdata, 32'h2A);
        advance();

        // Both ports requesting for 8 cycles.
        i_req = 1'b1; i_addr = 32'h4; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h18;
        for (int c = 1; c <= 8; c++) begin
            sample();
            chk($sformatf("starve_i_gnt_c%0d", c), {31'd0, i_gnt},
                {31'd0, GUARD && (c == LIMIT + 1)});
            chk($sformatf("starve_d_gnt_c%0d", c), {31'd0, d_gnt},
                {31'd0, !(GUARD && (c == LIMIT + 1))});
            advance();
        end
        d_req = 1'b0;
        sample();
        chk("starve_release", {31'd0, i_gnt}, 32'd1);
        advance();

        // Reset right after a read grant drops the response.
        i_addr = 32'h1C;
        sample();
        chk("rmid_gnt", {31'd0, i_gnt}, 32'd1);
        advance();
        reset = 1'b0; i_req = 1'b0;
        sample();
        chk("rmid_rvalid_rst", {31'd0, i_rvalid}, 32'd0);
        advance();
        reset = 1'b1;
        sample();
        chk("rmid_rvalid_after", {30'd0, i_rvalid, d_rvalid}, 32'd0);
        advance();

        // Random traffic; requests stay stable until the model says granted.
        for (int n = 0; n < 3000; n++) begin
            if (!i_req || (exp_iwin && reset)) begin
                i_req = ($urandom_range(0, 3) != 0);
                i_addr = $urandom;
                i_addr[9:2] = 8'($urandom_range(0, 15));
            end
            if (!d_req || (exp_dwin && reset)) begin
                d_req = ($urandom_range(0, 2) != 0);
                d_we = $urandom_range(0, 1) == 1;
                d_addr = $urandom;
                d_addr[9:2] = 8'($urandom_range(0, 15));
                d_wdata = $urandom;
            end
            reset = ($urandom_range(0, 63) != 0);
            advance();
        end
        reset = 1'b1; i_req = 1'b0; d_req = 1'b0;
        advance();
        advance();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
